// File: rtl/sfrx_pkg.sv
// sfrx_pkg: shared states, defaults and counter width helper for serial_frame_rx.
// The PARITY state exists only when SFRX_PARITY_EN is defined.
package sfrx_pkg;
    localparam int SFRX_DATA_W = 8;
    localparam int SFRX_CLKS_PER_BIT = 4;
`ifdef SFRX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} sfrx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} sfrx_state_e;
`endif
    function automatic int sfrx_cnt_w(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction
endpackage

// File: rtl/sfrx_bit_timer.sv
// sfrx_bit_timer: bit-period cycle counter with mid-bit and end-of-bit ticks.
module sfrx_bit_timer
    import sfrx_pkg::*;
#(
    parameter int CLKS_PER_BIT = SFRX_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);
    localparam int CW = sfrx_cnt_w(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (restart || full_tick) ? '0 : cnt + CW'(1);

    assign half_tick = cnt == CW'(HALF - 1);
    assign full_tick = cnt == CW'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/stop serial receiver with a one-entry valid/ready buffer.
// Define SFRX_PARITY_EN to add an even-parity bit after the data bits.
module serial_frame_rx
    import sfrx_pkg::*;
#(
    parameter int DATA_W       = SFRX_DATA_W,
    parameter int CLKS_PER_BIT = SFRX_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);
    localparam int BW = $clog2(DATA_W + 1);

    sfrx_state_e       state;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              half_tick, full_tick, restart, good;

    // Holding the counter at zero in IDLE makes the start edge E0 the timing origin.
    assign restart = state == IDLE || (state == START && half_tick);
    assign busy = state != IDLE;

    sfrx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

`ifdef SFRX_PARITY_EN
    logic par, par_bad;
    assign good = !par_bad;
`else
    assign good = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SFRX_PARITY_EN
            par        <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SFRX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: if (!in) state <= START;
                START: if (half_tick) begin
                    state   <= in ? IDLE : DATA;
                    bit_idx <= '0;
`ifdef SFRX_PARITY_EN
                    par     <= 1'b0;
                    par_bad <= 1'b0;
`endif
                end
                DATA: if (full_tick) begin
                    shreg   <= (shreg >> 1) | (DATA_W'(in) << (DATA_W - 1));
                    bit_idx <= bit_idx + BW'(1);
`ifdef SFRX_PARITY_EN
                    par <= par ^ in;
                    if (bit_idx == BW'(DATA_W - 1)) state <= PARITY;
`else
                    if (bit_idx == BW'(DATA_W - 1)) state <= STOP;
`endif
                end
`ifdef SFRX_PARITY_EN
                PARITY: if (full_tick) begin
                    parity_err <= par ^ in;
                    par_bad    <= par ^ in;
                    state      <= STOP;
                end
`endif
                STOP: if (full_tick) begin
                    state     <= in ? IDLE : WAIT_IDLE;
                    frame_err <= !in;
                    // A full buffer that is not being drained this edge keeps its word.
                    if (in && good) begin
                        if (!out_valid || out_ready) begin
                            out_data  <= shreg;
                            out_valid <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end
                end
                WAIT_IDLE: if (in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed checks of serial_frame_rx at default parameters.
module tb_serial_frame_rx;
    localparam int CPB = 4;
`ifdef SFRX_PARITY_EN
    localparam int LAT = 42;
`else
    localparam int LAT = 38;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, in = 1'b1, out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, busy, frame_err, overrun, parity_err;

    serial_frame_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_busy = 0, last_rise = 0, last_ov = 0;
    logic [7:0] rise_data = '0;
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (out_valid) n_valid <= n_valid + 1;
        if (frame_err) n_fe <= n_fe + 1;
        if (parity_err) n_pe <= n_pe + 1;
        if (busy) n_busy <= n_busy + 1;
        if (overrun) begin
            n_ov    <= n_ov + 1;
            last_ov <= cyc;
        end
        if (out_valid && !pv) begin
            last_rise <= cyc;
            rise_data <= out_data;
        end
        pv <= out_valid;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int e0 = 0;
    int s_v, s_f, s_o, s_p, s_b;
    task automatic snap();
        s_v = n_valid; s_f = n_fe; s_o = n_ov; s_p = n_pe; s_b = n_busy;
    endtask

    task automatic bit_out(input logic b);
        in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop);
        e0 = cyc + 1;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef SFRX_PARITY_EN
        bit_out(par);
`endif
        bit_out(stop);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_pe", parity_err, 0);
        rst_n = 1'b1;
        idle(4);

        snap();
        send(8'hA5, 1'b0, 1'b1);
        idle(8);
        chk("a5_cnt", n_valid - s_v, 1);
        chk("a5_data", rise_data, 8'hA5);
        chk("a5_lat", last_rise - e0, LAT);
        chk("a5_busy", busy, 0);
        chk("a5_fe", n_fe - s_f, 0);

        snap();
        in = 1'b0;
        @(negedge clk);
        idle(20);
        chk("gl_busy", n_busy - s_b, CPB / 2);
        chk("gl_valid", n_valid - s_v, 0);
        chk("gl_fe", n_fe - s_f, 0);

        snap();
        send(8'h3C, 1'b0, 1'b0);
        in = 1'b0;
        repeat (10) @(negedge clk);
        chk("fe_hold_busy", busy, 1);
        idle(8);
        chk("fe_cnt", n_fe - s_f, 1);
        chk("fe_valid", n_valid - s_v, 0);
        chk("fe_busy", busy, 0);
        snap();
        send(8'h11, 1'b0, 1'b1);
        idle(8);
        chk("fe_next_data", rise_data, 8'h11);
        chk("fe_next_cnt", n_valid - s_v, 1);

        out_ready = 1'b0;
        snap();
        send(8'h01, 1'b1, 1'b1);
        idle(4);
        send(8'h02, 1'b1, 1'b1);
        idle(8);
        chk("ov_cnt", n_ov - s_o, 1);
        chk("ov_when", last_ov - e0, LAT);
        chk("ov_data", out_data, 8'h01);
        chk("ov_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ov_drain", out_valid, 0);

        snap();
        e0 = cyc + 1;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i == 0 ? 1'b0 : 1'b1);
        in = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_data", out_data, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_fe", frame_err, 0);
        chk("ar_ov", overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(CPB * 12);
        chk("ar_fe_cnt", n_fe - s_f, 0);
        chk("ar_ov_cnt", n_ov - s_o, 0);
        chk("ar_valid_cnt", n_valid - s_v, 0);
        snap();
        send(8'h7E, 1'b0, 1'b1);
        idle(8);
        chk("ar_rx_data", rise_data, 8'h7E);
        chk("ar_rx_lat", last_rise - e0, LAT);

`ifdef SFRX_PARITY_EN
        snap();
        send(8'h03, 1'b1, 1'b1);
        idle(8);
        chk("par_bad_pe", n_pe - s_p, 1);
        chk("par_bad_valid", n_valid - s_v, 0);
        snap();
        send(8'h03, 1'b0, 1'b1);
        idle(8);
        chk("par_ok_data", rise_data, 8'h03);
        chk("par_ok_lat", last_rise - e0, 42);
        chk("par_ok_pe", n_pe - s_p, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
